ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set, 0xFF reset)
//  to the keyboard over the shared open-drain PS/2 clock/data lines.

---
 rtl/ps2_host_tx.sv | 247 ++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, ack.
// Optional macro PS2_TX_RETRY_EN: retry a failed frame up to twice before reporting tx_err.
module ps2_host_tx #(
    parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
    parameter int unsigned INHIBIT_US   = 100,
    parameter int unsigned SETUP_US     = 1,
    parameter int unsigned START_TMO_US = 15000,
    parameter int unsigned BIT_TMO_US   = 2000
) (
    input  logic       I_clk_100M,
    input  logic       I_rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       tx_valid,
    input  logic [7:0] tx_byte,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [2:0] dbg_state
);

    // Handshake: a byte is taken on any cycle where tx_valid && tx_ready; tx_ready is high only in
    // IDLE and tx_valid is ignored at all other times.

    localparam longint unsigned INH_RAW = 64'(INHIBIT_US)   * 64'(CLK_FREQ_HZ) / 64'd1_000_000;
    localparam longint unsigned SET_RAW = 64'(SETUP_US)     * 64'(CLK_FREQ_HZ) / 64'd1_000_000;
    localparam longint unsigned STA_RAW = 64'(START_TMO_US) * 64'(CLK_FREQ_HZ) / 64'd1_000_000;
    localparam longint unsigned BIT_RAW = 64'(BIT_TMO_US)   * 64'(CLK_FREQ_HZ) / 64'd1_000_000;
    localparam longint unsigned INH_CYC = (INH_RAW == 0) ? 64'd1 : INH_RAW;
    localparam longint unsigned SET_CYC = (SET_RAW == 0) ? 64'd1 : SET_RAW;
    localparam longint unsigned STA_CYC = (STA_RAW == 0) ? 64'd1 : STA_RAW;
    localparam longint unsigned BIT_CYC = (BIT_RAW == 0) ? 64'd1 : BIT_RAW;
    localparam longint unsigned MAX_AB  = (INH_CYC > SET_CYC) ? INH_CYC : SET_CYC;
    localparam longint unsigned MAX_CD  = (STA_CYC > BIT_CYC) ? STA_CYC : BIT_CYC;
    localparam longint unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int              CNT_W   = $clog2(MAX_CYC + 64'd1);

    localparam logic [CNT_W-1:0] INH_LD = CNT_W'(INH_CYC - 64'd1);
    localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SET_CYC - 64'd1);
    localparam logic [CNT_W-1:0] STA_LD = CNT_W'(STA_CYC);
    localparam logic [CNT_W-1:0] BIT_LD = CNT_W'(BIT_CYC);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_XFER, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             parity_q, parity_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clk_meta_q, clk_sync_q, clk_prev_q;
    logic             data_meta_q, data_sync_q;
    logic             fall, fail;
    logic [3:0]       nxt_bit;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]       retry_q, retry_d;
`endif

    assign fall = clk_prev_q & ~clk_sync_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        byte_d    = byte_q;
        parity_d  = parity_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fail      = 1'b0;
        nxt_bit   = bit_cnt_q + 4'd1;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tx_valid && ready_q) begin
                    byte_d    = tx_byte;
                    parity_d  = ~^tx_byte;
                    state_d   = S_INHIBIT;
                    cnt_d     = INH_LD;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
                    retry_d   = 2'd0;
`endif
                end
            end
            S_INHIBIT: begin
                if (cnt_q == '0) begin
                    state_d   = S_REQ;
                    data_oe_d = 1'b1;
                    cnt_d     = SET_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_REQ: begin
                if (cnt_q == '0) begin
                    state_d   = S_XFER;
                    clk_oe_d  = 1'b0;
                    bit_cnt_d = 4'd0;
                    cnt_d     = STA_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_XFER: begin
                if (fall) begin
                    bit_cnt_d = nxt_bit;
                    cnt_d     = BIT_LD;
                    if (nxt_bit <= 4'd8) begin
                        data_oe_d = ~byte_q[nxt_bit[2:0] - 3'd1];
                    end else if (nxt_bit == 4'd9) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end else if (cnt_q <= ONE) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_ACK: begin
                if (fall) begin
                    if (!data_sync_q) begin
                        state_d = S_WAIT_IDLE;
                        cnt_d   = BIT_LD;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (cnt_q <= ONE) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync_q && data_sync_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (fall) begin
                    cnt_d = BIT_LD;
                end else if (cnt_q <= ONE) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
`ifdef PS2_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                retry_d   = retry_q + 2'd1;
                state_d   = S_INHIBIT;
                cnt_d     = INH_LD;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
            end else begin
                state_d   = S_ERR;
                err_d     = 1'b1;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
`else
            state_d   = S_ERR;
            err_d     = 1'b1;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
`endif
        end

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge I_clk_100M or posedge I_rst) begin
        if (I_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= 4'd0;
            byte_q      <= 8'd0;
            parity_q    <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_q      <= byte_d;
            parity_q    <= parity_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_ready    = ready_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural keyboard on the open-drain lines.
// Runs at CLK_FREQ_HZ = 1 MHz: inhibit 100 cycles, setup 1, start timeout 15000, bit timeout 2000.
module tb_ps2_host_tx;

    localparam int INH  = 100;
    localparam int SETC = 1;
    localparam int STA  = 15000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic [2:0] dbg_state;
    logic       dev_clk_low, dev_data_low;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.CLK_FREQ_HZ(1_000_000)) dut (
        .I_clk_100M (clk),
        .I_rst      (rst),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_valid   (tx_valid),
        .tx_byte    (tx_byte),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err)  err_cnt++;
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: observed no finish, expected finish before 5 ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: one-cycle tx_valid pulse
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_byte  = b;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // keyboard model: waits for request-to-send, clocks the frame, optionally acks
    task automatic dev_frame(input int nfalls, input bit ack_low,
                             output logic [10:1] bits, output bit seen);
        int w;
        bits = '0;
        seen = 1'b0;
        w = 0;
        while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5000) return;
        seen = 1'b1;
        repeat (30) @(negedge clk);
        for (int f = 1; f <= nfalls && f <= 10; f++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            bits[f] = ps2_data_in;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        if (nfalls >= 11) begin
            dev_data_low = ack_low;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (5) @(negedge clk);
            dev_data_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic frame_ok(input string tag, input logic [7:0] b, input logic par);
        logic [10:1] bits;
        bit          seen;
        int          d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        dev_frame(11, 1'b1, bits, seen);
        repeat (10) @(negedge clk);
        check({tag, "_seen"},   32'(seen), 32'd1);
        check({tag, "_data"},   32'(bits[8:1]), 32'(b));
        check({tag, "_parity"}, 32'(bits[9]), 32'(par));
        check({tag, "_stop"},   32'(bits[10]), 32'd1);
        check({tag, "_done"},   32'(done_cnt - d0), 32'd1);
        check({tag, "_noerr"},  32'(err_cnt - e0), 32'd0);
        check({tag, "_ready"},  32'(tx_ready), 32'd1);
        check({tag, "_oe"},     32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    endtask

    initial begin
        logic [10:1] bits;
        bit          seen;
        int          k, d0, e0, nseen;

        rst = 1'b1;
        tx_valid = 1'b0;
        tx_byte = 8'h00;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy",  32'(tx_busy), 32'd0);
        check("rst_oe",    32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("rst_pulse", 32'({tx_done, tx_err}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: 0xED with ack, inhibit and setup durations
        send(8'hED);
        check("t1_busy", 32'({tx_busy, tx_ready}), 32'b10);
        k = 0;
        while (ps2_clk_oe && !ps2_data_oe && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("t1_inhibit_cycles", 32'(k), 32'(INH));
        k = 0;
        while (ps2_clk_oe && ps2_data_oe && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("t1_setup_cycles", 32'(k), 32'(SETC));
        frame_ok("t1", 8'hED, 1'b1);

        // 2: parity 0 and parity 1
        send(8'h01);
        frame_ok("t2a", 8'h01, 1'b0);
        send(8'hFF);
        frame_ok("t2b", 8'hFF, 1'b1);

        // 3: device leaves data high at the ack fall
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hED);
`ifdef PS2_TX_RETRY_EN
        nseen = 0;
        for (int a = 0; a < 3; a++) begin
            dev_frame(11, 1'b0, bits, seen);
            nseen += int'(seen);
            if (a == 0) check("t3_no_err_first", 32'(err_cnt - e0), 32'd0);
        end
        check("t3_attempts", 32'(nseen), 32'd3);
`else
        dev_frame(11, 1'b0, bits, seen);
        check("t3_data", 32'(bits[8:1]), 32'hED);
`endif
        repeat (10) @(negedge clk);
        check("t3_err",    32'(err_cnt - e0), 32'd1);
        check("t3_nodone", 32'(done_cnt - d0), 32'd0);
        check("t3_oe",     32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("t3_ready",  32'(tx_ready), 32'd1);

        // 4: no device clock after release
        e0 = err_cnt;
        send(8'hAA);
        k = 0;
        while (ps2_clk_oe && k < 1000) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (!tx_err && k < 60000) begin
            @(negedge clk);
            k++;
        end
`ifdef PS2_TX_RETRY_EN
        check("t4_tmo_cycles", 32'(k), 32'(3 * STA + 2 * (INH + SETC)));
`else
        check("t4_tmo_cycles", 32'(k), 32'(STA));
`endif
        repeat (5) @(negedge clk);
        check("t4_err", 32'(err_cnt - e0), 32'd1);
        check("t4_oe",  32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

        // 5: reset after bit 4 (bit 3 of 0xF4 is 0, so data is being pulled low)
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hF4);
        dev_frame(4, 1'b1, bits, seen);
        check("t5_pre_data_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_oe",    32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("t5_rst_ready", 32'({tx_ready, tx_busy}), 32'b10);
        check("t5_rst_state", 32'(dbg_state), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        send(8'hF4);
        frame_ok("t5", 8'hF4, 1'b0);

        // 6: tx_valid while busy is ignored
        send(8'hED);
        repeat (5) @(negedge clk);
        tx_valid = 1'b1;
        tx_byte  = 8'h55;
        @(negedge clk);
        tx_valid = 1'b0;
        frame_ok("t6", 8'hED, 1'b1);
        repeat (50) @(negedge clk);
        check("t6_no_second", 32'({tx_busy, ps2_clk_oe}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
